// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO between a core-side MMIO writer and a UART
// transmitter. A three-state handshake pops one byte whenever the
// transmitter is idle, presents it on tx_data and pulses tx_start once.
module uart_tx_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_ready
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;

    logic               w_wr;
    logic               w_ovf_ev;
    logic               w_pop;

    // Write acceptance, overflow detection and next occupancy.
    // A write into a full FIFO is dropped even when a pop frees a slot in
    // the same cycle, so acceptance looks only at the registered full flag.
    always_comb begin
        w_wr         = wr_en & ~r_full;
        w_ovf_ev     = wr_en & r_full;
        w_count_next = r_count;
        if (w_wr && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_wr && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // FIFO storage; contents need no reset because pointers and count gate every read.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == CNT_W'(DEPTH));
        end
    end

    // Sticky overflow; a dropped write wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_ev) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and pop decision: pop only from IDLE with data and an idle transmitter.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty && tx_ready) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!tx_ready) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output register: start pulse follows each pop by one cycle, data held until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rptr];
            end
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

endmodule
